// File: rtl/quad_step_decoder_pkg.sv
// rtl/quad_step_decoder_pkg.sv - shared types, Gray constants and step classifier for the quadrature decoder
package quad_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_e;

  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q01 = 2'b01;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q10 = 2'b10;

  // Result of comparing two consecutive {A,B} samples
  typedef enum logic [1:0] {
    MOVE_NONE = 2'b00,
    MOVE_UP   = 2'b01,
    MOVE_DN   = 2'b10,
    MOVE_ILL  = 2'b11
  } move_e;

  // Forward order is 00->01->11->10->00; a change of both bits has no direction
  function automatic move_e quad_move(input logic [1:0] prev, input logic [1:0] cur);
    move_e m;
    m = MOVE_NONE;
    if (prev == cur) begin
      m = MOVE_NONE;
    end else if ((prev ^ cur) == 2'b11) begin
      m = MOVE_ILL;
    end else begin
      case (prev)
        Q00:     m = (cur == Q01) ? MOVE_UP : MOVE_DN;
        Q01:     m = (cur == Q11) ? MOVE_UP : MOVE_DN;
        Q11:     m = (cur == Q10) ? MOVE_UP : MOVE_DN;
        default: m = (cur == Q00) ? MOVE_UP : MOVE_DN;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/quad_step_decoder_if.sv
// rtl/quad_step_decoder_if.sv - encoder inputs and step/direction/status outputs of the decoder
interface quad_step_decoder_if;
  logic a_in;
  logic b_in;
  logic clr_err;
  logic step;
  logic ud;
  logic err;
  logic err_flag;
  logic ready;

  modport master (
    output a_in, b_in, clr_err,
    input  step, ud, err, err_flag, ready
  );

  modport slave (
    input  a_in, b_in, clr_err,
    output step, ud, err, err_flag, ready
  );
endinterface

// File: rtl/quad_step_decoder_glitch_filter.sv
// rtl/quad_step_decoder_glitch_filter.sv - per-channel synchroniser and persistence filter
module quad_glitch_filter
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic bypass_i,
  input  logic raw_i,
  output logic filt_o
);
  localparam int FILT_W = $clog2(FILT_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILT_W-1:0]      cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];
  assign filt_o = filt_q;

  // Plain shift chain; nothing between the flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
  end

  // Accept a new level only after it has disagreed with the output for FILT_LEN cycles in a row
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (bypass_i) begin
      filt_d = synced;
    end else if (synced != filt_q) begin
      if (cnt_q == FILT_W'(FILT_LEN - 1)) filt_d = synced;
      else                                cnt_d  = cnt_q + FILT_W'(1);
    end
  end

  // Filter state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end
endmodule

// File: rtl/quad_step_decoder.sv
// rtl/quad_step_decoder.sv - quadrature A/B decoder producing step pulses, direction and error status
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 8
) (
  input  logic               clk,
  input  logic               rst,
  quad_step_decoder_if.slave bus
);
  localparam int INIT_CYCLES = SYNC_STAGES + FILT_LEN;
  localparam int INIT_W      = $clog2(INIT_CYCLES + 1);

  state_e            state_q, state_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic              a_f, b_f;
  logic              bypass;
  logic [1:0]        cur, prev_q;
  move_e             move;
  logic              step_q, step_d;
  logic              err_q, err_d;
  logic              ud_q, ud_d;
  logic              flag_q, flag_d;

  assign bypass = (state_q == INIT);
  assign cur    = {a_f, b_f};

  quad_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
    .clk      (clk),
    .rst      (rst),
    .bypass_i (bypass),
    .raw_i    (bus.a_in),
    .filt_o   (a_f)
  );

  quad_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
    .clk      (clk),
    .rst      (rst),
    .bypass_i (bypass),
    .raw_i    (bus.b_in),
    .filt_o   (b_f)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= INIT;
    else     state_q <= state_d;
  end

  // Leave INIT once the synchroniser and filter pipelines have been flushed with real input
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == INIT) begin
      init_cnt_d = init_cnt_q + INIT_W'(1);
      if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) state_d = TRACK;
    end
  end

  // Decode the filtered position change; nothing is reported while still in INIT
  always_comb begin
    move   = quad_move(prev_q, cur);
    step_d = 1'b0;
    err_d  = 1'b0;
    ud_d   = ud_q;
    flag_d = flag_q;
    if (state_q == TRACK) begin
      case (move)
        MOVE_UP:  begin step_d = 1'b1; ud_d = 1'b1; end
        MOVE_DN:  begin step_d = 1'b1; ud_d = 1'b0; end
        MOVE_ILL: err_d = 1'b1;
        default:  ;
      endcase
      // A new error outranks a simultaneous clear
      if (err_d)            flag_d = 1'b1;
      else if (bus.clr_err) flag_d = 1'b0;
    end
  end

  // Datapath registers; prev follows cur every cycle so INIT exits with the power-up position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt_q <= '0;
      prev_q     <= Q00;
      step_q     <= 1'b0;
      err_q      <= 1'b0;
      ud_q       <= 1'b1;
      flag_q     <= 1'b0;
    end else begin
      init_cnt_q <= init_cnt_d;
      prev_q     <= cur;
      step_q     <= step_d;
      err_q      <= err_d;
      ud_q       <= ud_d;
      flag_q     <= flag_d;
    end
  end

  assign bus.step     = step_q;
  assign bus.err      = err_q;
  assign bus.ud       = ud_q;
  assign bus.err_flag = flag_q;
  assign bus.ready    = (state_q == TRACK);
endmodule

// File: tb/tb_quad_step_decoder.sv
// tb/tb_quad_step_decoder.sv - scoreboard bench for quad_step_decoder against a cycle-history reference model
module tb_quad_step_decoder;
  localparam int SYNC     = 2;
  localparam int FILT     = 8;
  localparam int INIT_LEN = SYNC + FILT;

  logic clk = 1'b0;
  logic rst = 1'b1;

  quad_step_decoder_if bus ();

  quad_step_decoder #(.SYNC_STAGES(SYNC), .FILT_LEN(FILT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    bit is_err;
    bit ud;
  } ev_t;

  ev_t sb[$];
  int  vectors     = 0;
  int  miscompares = 0;

  // Reference model state: raw samples and filtered levels indexed by edge number since reset release
  int n = 0;
  bit ra[$], rb[$], pa[$], pb[$];
  bit m_ud = 1'b1, m_flag = 1'b0, m_ready = 1'b0;

  // Position of a Gray code along the forward sequence 00,01,11,10
  function automatic int pos(input bit a, input bit b);
    case ({a, b})
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, n);
    end
  endtask

  // Reference model, one step per rising edge
  initial begin
    ra.push_back(1'b0); rb.push_back(1'b0); pa.push_back(1'b0); pb.push_back(1'b0);
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        n = 0;
        ra.delete(); rb.delete(); pa.delete(); pb.delete();
        ra.push_back(1'b0); rb.push_back(1'b0); pa.push_back(1'b0); pb.push_back(1'b0);
        m_ud = 1'b1; m_flag = 1'b0; m_ready = 1'b0;
        sb.delete();
      end else begin
        bit na, nb, alla, allb;
        int d;
        n++;
        ra.push_back(bus.a_in);
        rb.push_back(bus.b_in);
        if (n <= INIT_LEN) begin
          na = (n - SYNC >= 0) ? ra[n-SYNC] : 1'b0;
          nb = (n - SYNC >= 0) ? rb[n-SYNC] : 1'b0;
        end else begin
          alla = 1'b1; allb = 1'b1;
          for (int k = n - SYNC - FILT + 1; k <= n - SYNC; k++) begin
            if (ra[k] == pa[n-1]) alla = 1'b0;
            if (rb[k] == pb[n-1]) allb = 1'b0;
          end
          na = alla ? ~pa[n-1] : pa[n-1];
          nb = allb ? ~pb[n-1] : pb[n-1];
        end
        pa.push_back(na);
        pb.push_back(nb);
        m_ready = (n >= INIT_LEN);
        if (n >= INIT_LEN + 1) begin
          d = (pos(pa[n-1], pb[n-1]) - pos(pa[n-2], pb[n-2]) + 4) % 4;
          if (d == 1 || d == 3) begin
            m_ud = (d == 1);
            sb.push_back('{n, 1'b0, m_ud});
          end else if (d == 2) begin
            sb.push_back('{n, 1'b1, m_ud});
          end
          if (d == 2)           m_flag = 1'b1;
          else if (bus.clr_err) m_flag = 1'b0;
        end
      end
    end
  end

  // Monitor: compares DUT outputs mid-cycle against the scoreboard and model levels
  initial begin
    ev_t ev;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("ready", bus.ready, m_ready);
        check("ud", bus.ud, m_ud);
        check("err_flag", bus.err_flag, m_flag);
        if (bus.step && bus.err) check("step_err_overlap", 1, 0);
        if (bus.step || bus.err) begin
          if (sb.size() == 0) begin
            check("unexpected_pulse", {bus.step, bus.err}, 0);
          end else begin
            ev = sb.pop_front();
            check("pulse_cycle", n, ev.due);
            check("pulse_is_err", bus.err, ev.is_err);
            check("pulse_ud", bus.ud, ev.ud);
          end
        end else if (sb.size() > 0 && sb[0].due <= n) begin
          ev = sb.pop_front();
          check("missing_pulse_due", n + 1000000, ev.due);
        end
      end
    end
  end

  task automatic drive(input bit a, input bit b, input int hold, input bit clr);
    bus.a_in    = a;
    bus.b_in    = b;
    bus.clr_err = clr;
    @(posedge clk); #1;
    bus.clr_err = 1'b0;
    repeat (hold - 1) @(posedge clk);
    #1;
  endtask

  // Illegal jump with clr_err timed to land on the same edge as err
  task automatic err_with_clear(input bit a, input bit b);
    bus.a_in = a;
    bus.b_in = b;
    repeat (SYNC + FILT) @(posedge clk);
    #1 bus.clr_err = 1'b1;
    @(posedge clk); #1 bus.clr_err = 1'b0;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse_mid_cycle();
    #2 rst = 1'b1;
    #1;
    check("rst_step", bus.step, 0);
    check("rst_err", bus.err, 0);
    check("rst_err_flag", bus.err_flag, 0);
    check("rst_ready", bus.ready, 0);
    check("rst_ud", bus.ud, 1);
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    bus.a_in = 1'b1; bus.b_in = 1'b1; bus.clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    // Power-up at 11: no step, ready after INIT
    repeat (40) @(posedge clk);
    #1;
    drive(1, 0, 20, 0);
    drive(0, 0, 20, 0);
    // Forward then reverse revolution
    drive(0, 1, 20, 0); drive(1, 1, 20, 0); drive(1, 0, 20, 0); drive(0, 0, 20, 0);
    drive(1, 0, 20, 0); drive(1, 1, 20, 0); drive(0, 1, 20, 0); drive(0, 0, 20, 0);
    // Glitch just below and exactly at the filter length
    drive(1, 0, FILT - 1, 0); drive(0, 0, 20, 0);
    drive(1, 0, FILT, 0);     drive(0, 0, 20, 0);
    // Illegal jump, clear, then illegal jump with coincident clear
    drive(1, 1, 20, 0);
    drive(1, 1, 5, 1);
    err_with_clear(0, 0);
    // Leave ud=0 and err_flag=1, then reset while a filter count is pending
    drive(1, 0, 20, 0);
    drive(1, 1, 5, 0);
    reset_pulse_mid_cycle();
    repeat (30) @(posedge clk);
    #1;
    // Randomised segments, including short glitches, illegal jumps and occasional resets
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 39) == 0) reset_pulse_mid_cycle();
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(1, 30), ($urandom_range(0, 7) == 0));
    end
    repeat (40) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
